apb_uart_master: RTL and testbench

//  APB3 requester that drives the UART's APB completer port (PSELx/PENABLE/PWRITE/PADDR/PWDATA).

---
 rtl/apb_uart_master.sv | 186 ++++++++++++++++++
 tb/tb_apb_uart_master.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_uart_master.sv
// ----------------------------------------------------------------------------
// apb_uart_master
//
// APB3 requester that drives the UART's APB completer port. It takes commands
// from firmware or sequencer logic as a valid/ready stream, runs each one as a
// single APB transfer, and returns PRDATA/PSLVERR as a response. Only one
// transfer is outstanding at a time.
//
// Handshake rule for both streams: a beat transfers on a rising PCLK edge where
// valid and ready are both 1. The source holds its payload stable while valid
// is 1 and ready is 0. The sink may raise or lower ready at any time.
//
// Ports
//   PCLK, PRESET       clock and synchronous active-high reset
//   cmd_valid/ready    command stream: cmd_write, cmd_addr, cmd_wdata
//   rsp_valid/ready    response stream: rsp_rdata, rsp_err, rsp_timeout
//   PSELx .. PWDATA    APB request signals to the completer
//   PRDATA .. PSLVERR  APB completion signals from the completer
//   dbg_state_o        current FSM state: 0 IDLE, 1 SETUP, 2 ACCESS, 3 RESP
// ----------------------------------------------------------------------------
module apb_uart_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  PSELx,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR,
    output logic [1:0]            dbg_state_o
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    // The counter must be able to hold TIMEOUT_CYCLES.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // Value of the counter during the last permitted wait cycle.
    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [1:0]            state_q,     state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q,   rsp_err_d;
    logic                  rsp_to_q,    rsp_to_d;
    logic                  psel_q,      psel_d;
    logic                  penable_q,   penable_d;
    logic                  pwrite_q,    pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q,     paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q,    pwdata_d;
    logic [CNT_W-1:0]      wait_cnt_q,  wait_cnt_d;
    logic                  timeout_hit;

    // A TIMEOUT_CYCLES of 0 disables the abort path entirely.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt_q == TO_LAST);

    always_comb begin
        state_d     = state_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_to_d    = rsp_to_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        wait_cnt_d  = wait_cnt_q;

        case (state_q)
            ST_IDLE: begin
                // cmd_ready_q is only ever 1 while idle, so this is the accept.
                if (cmd_valid && cmd_ready_q) begin
                    pwrite_d   = cmd_write;
                    paddr_d    = cmd_addr;
                    pwdata_d   = cmd_wdata;
                    psel_d     = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = ST_SETUP;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                    rsp_err_d   = PSLVERR;
                    rsp_to_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    state_d     = ST_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    if (timeout_hit) begin
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b1;
                        rsp_to_d    = 1'b1;
                        rsp_valid_d = 1'b1;
                        psel_d      = 1'b0;
                        penable_d   = 1'b0;
                        state_d     = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered ready: high exactly in the cycles spent in IDLE, except
        // the first cycle out of reset.
        cmd_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_to_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_to_q    <= rsp_to_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_to_q;
    assign PSELx       = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_apb_uart_master.sv
// ----------------------------------------------------------------------------
// tb_apb_uart_master
//
// Bench for apb_uart_master built with TIMEOUT_CYCLES = 4. A completer model
// chooses the wait states, error flag and read data for every transfer. The
// expected response of each command is computed when the command is issued,
// using the transfer rules: a timeout gives err=1, timeout=1 and rdata=0; any
// other result gives timeout=0, err=PSLVERR and rdata=(write ? 0 : PRDATA).
// This response is queued and compared when rsp_valid appears. APB phase
// timing and backpressure behaviour are checked cycle by cycle.
// ----------------------------------------------------------------------------
module tb_apb_uart_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    // ---------------- clock / reset ----------------
    logic PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    logic          PRESET;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err, rsp_timeout;
    logic          PSELx, PENABLE, PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA, PRDATA;
    logic          PREADY, PSLVERR;
    logic [1:0]    dbg_state;

    apb_uart_master #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .PCLK       (PCLK),
        .PRESET     (PRESET),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .PSELx      (PSELx),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR),
        .dbg_state_o(dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_err    = 0;
    logic [DW+1:0] exp_q[$];   // {timeout, err, rdata}

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    // ---------------- driver ----------------
    // waits: number of PREADY=0 cycles in ACCESS before the completer answers.
    // bp: number of RESP cycles with rsp_ready held low (and cmd_valid high).
    task automatic do_txn(input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input int waits,
                          input logic err, input logic [DW-1:0] rdata,
                          input int bp);
        int            guard;
        int            k;
        bit            done;
        logic [DW+1:0] exp_rsp;

        guard = 0;
        while (cmd_ready !== 1'b1 && guard < 20) begin
            step();
            guard++;
        end
        check_val("cmd_ready_before_issue", cmd_ready, 1);

        if (waits >= TO) exp_q.push_back({2'b11, {DW{1'b0}}});
        else             exp_q.push_back({1'b0, err, (wr ? {DW{1'b0}} : rdata)});

        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        PREADY    = 1'($urandom_range(0, 1));
        step();

        // SETUP: request fields latched, command bus now junk.
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom_range(0, 1));
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        check_val("setup_psel", PSELx, 1);
        check_val("setup_penable", PENABLE, 0);
        check_val("setup_paddr", PADDR, addr);
        check_val("setup_pwrite", PWRITE, wr);
        if (wr) check_val("setup_pwdata", PWDATA, wdata);
        check_val("setup_cmd_ready", cmd_ready, 0);
        check_val("setup_rsp_valid", rsp_valid, 0);
        PREADY  = 1'($urandom_range(0, 1));
        PSLVERR = 1'($urandom_range(0, 1));
        PRDATA  = $urandom;
        step();

        // ACCESS, possibly with wait states.
        k    = 0;
        done = 1'b0;
        while (!done) begin
            check_val("access_psel", PSELx, 1);
            check_val("access_penable", PENABLE, 1);
            check_val("access_paddr", PADDR, addr);
            check_val("access_pwrite", PWRITE, wr);
            if (wr) check_val("access_pwdata", PWDATA, wdata);
            check_val("access_rsp_valid", rsp_valid, 0);
            if (k == waits) begin
                PREADY  = 1'b1;
                PRDATA  = rdata;
                PSLVERR = err;
            end else begin
                PREADY  = 1'b0;
                PRDATA  = $urandom;
                PSLVERR = 1'($urandom_range(0, 1));
            end
            step();
            k++;
            if (k == waits + 1 || k == TO) done = 1'b1;
        end
        PREADY  = 1'b0;
        PSLVERR = 1'b0;

        // RESP
        if (exp_q.size() == 0) begin
            check_val("exp_q_empty", 1, 0);
            exp_rsp = '0;
        end else begin
            exp_rsp = exp_q.pop_front();
        end
        check_val("resp_valid", rsp_valid, 1);
        check_val("resp_psel", PSELx, 0);
        check_val("resp_penable", PENABLE, 0);
        check_val("resp_cmd_ready", cmd_ready, 0);
        check_val("resp_payload", {rsp_timeout, rsp_err, rsp_rdata}, exp_rsp);
        check_val("resp_paddr_hold", PADDR, addr);

        for (int i = 0; i < bp; i++) begin
            rsp_ready = 1'b0;
            cmd_valid = 1'b1;
            cmd_write = 1'($urandom_range(0, 1));
            cmd_addr  = $urandom;
            cmd_wdata = $urandom;
            step();
            check_val("bp_rsp_valid", rsp_valid, 1);
            check_val("bp_payload", {rsp_timeout, rsp_err, rsp_rdata}, exp_rsp);
            check_val("bp_cmd_ready", cmd_ready, 0);
            check_val("bp_psel", PSELx, 0);
            check_val("bp_paddr_hold", PADDR, addr);
        end

        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check_val("idle_rsp_valid", rsp_valid, 0);
        check_val("idle_cmd_ready", cmd_ready, 1);
        check_val("idle_psel", PSELx, 0);
        check_val("idle_paddr_hold", PADDR, addr);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        PRESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        step();
        step();

        // Reset values
        check_val("rst_cmd_ready", cmd_ready, 0);
        check_val("rst_rsp_valid", rsp_valid, 0);
        check_val("rst_rsp_rdata", rsp_rdata, 0);
        check_val("rst_rsp_err", rsp_err, 0);
        check_val("rst_rsp_timeout", rsp_timeout, 0);
        check_val("rst_psel", PSELx, 0);
        check_val("rst_penable", PENABLE, 0);
        check_val("rst_pwrite", PWRITE, 0);
        check_val("rst_paddr", PADDR, 0);
        check_val("rst_pwdata", PWDATA, 0);

        PRESET = 1'b0;
        step();
        check_val("post_rst_cmd_ready", cmd_ready, 1);

        // Directed cases
        do_txn(1'b1, 32'h0000_0004, 32'h0000_00A5, 0, 1'b0, 32'h0, 0);         // write, no wait
        do_txn(1'b0, 32'h0000_0008, 32'h0, 3, 1'b0, 32'h0000_005A, 0);         // read, 3 waits
        do_txn(1'b0, 32'h0000_0FFC, 32'h0, 0, 1'b1, 32'h0000_1234, 0);         // slave error
        do_txn(1'b0, 32'h0000_0010, 32'h0, 10, 1'b0, 32'hDEAD_BEEF, 0);        // timeout
        do_txn(1'b1, 32'h0000_0014, 32'hCAFE_F00D, 4, 1'b1, 32'h0, 0);         // write timeout
        do_txn(1'b1, 32'h0000_000C, 32'h1357_9BDF, 1, 1'b0, 32'h0, 5);         // backpressure

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            do_txn(1'($urandom_range(0, 1)), $urandom, $urandom,
                   int'($urandom_range(0, 5)), 1'($urandom_range(0, 3) == 0),
                   $urandom, int'($urandom_range(0, 2)));
        end

        // Reset during an ACCESS wait state: transfer abandoned, no response.
        check_val("rst_mid_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h0000_0ABC;
        cmd_wdata = 32'h1111_2222;
        step();
        cmd_valid = 1'b0;
        PREADY    = 1'b0;
        step();
        check_val("rst_mid_access_penable", PENABLE, 1);
        step();
        step();
        PRESET = 1'b1;
        step();
        check_val("rst_mid_psel", PSELx, 0);
        check_val("rst_mid_penable", PENABLE, 0);
        check_val("rst_mid_rsp_valid", rsp_valid, 0);
        check_val("rst_mid_paddr", PADDR, 0);
        check_val("rst_mid_pwdata", PWDATA, 0);
        PRESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_val("post_rst_no_rsp", rsp_valid, 0);
            check_val("post_rst_psel", PSELx, 0);
            check_val("post_rst_cmd_ready", cmd_ready, 1);
        end

        // Normal operation after the abandoned transfer
        do_txn(1'b0, 32'h0000_0020, 32'h0, 2, 1'b0, 32'h0BAD_CAFE, 1);
        check_val("exp_q_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
